// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter giving CORE_COUNT cores turns at a single shared memory port.
// Optional BUSY watchdog is compiled in with `define ARB_TIMEOUT_EN (arb_error tied low otherwise).

module core_mem_arbiter #(
    parameter int CORE_COUNT     = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ENABLE_SIZE    = 2,
    parameter int ADDR_SIZE      = 16,
    parameter int REG_SIZE       = 32,
    parameter logic [ENABLE_SIZE-1:0] ENABLE_WRITE = ENABLE_SIZE'(2)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [CORE_COUNT*ENABLE_SIZE-1:0] core_enable,
    input  logic [CORE_COUNT*ADDR_SIZE-1:0]   core_addr,
    input  logic [CORE_COUNT*REG_SIZE-1:0]    core_wr_data,
    output logic [CORE_COUNT-1:0]             core_ready,
    output logic [REG_SIZE-1:0]               core_rd_data,
    output logic [ENABLE_SIZE-1:0]            mem_enable,
    output logic [ADDR_SIZE-1:0]              mem_addr,
    output logic [REG_SIZE-1:0]               mem_wr_data,
    input  logic [REG_SIZE-1:0]               mem_rd_data,
    input  logic                              mem_ready,
    output logic                              arb_error
);

    localparam int PTR_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

    if (CORE_COUNT < 2 || CORE_COUNT > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("core_mem_arbiter: CORE_COUNT must be 2..16 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    logic [ENABLE_SIZE-1:0] en_s    [CORE_COUNT];
    logic [ADDR_SIZE-1:0]   addr_s  [CORE_COUNT];
    logic [REG_SIZE-1:0]    wdata_s [CORE_COUNT];

    for (genvar g = 0; g < CORE_COUNT; g++) begin : g_unpack
        assign en_s[g]    = core_enable[g*ENABLE_SIZE +: ENABLE_SIZE];
        assign addr_s[g]  = core_addr[g*ADDR_SIZE +: ADDR_SIZE];
        assign wdata_s[g] = core_wr_data[g*REG_SIZE +: REG_SIZE];
    end

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       grant_q, grant_d;
    logic [ENABLE_SIZE-1:0] req_en_q, req_en_d;
    logic [ADDR_SIZE-1:0]   req_addr_q, req_addr_d;
    logic [REG_SIZE-1:0]    req_wdata_q, req_wdata_d;
    logic [REG_SIZE-1:0]    rd_data_q, rd_data_d;
    logic [CORE_COUNT-1:0]  core_ready_q, core_ready_d;
    logic [ENABLE_SIZE-1:0] mem_enable_q, mem_enable_d;
    logic                   pick_found_s;
    logic [PTR_W-1:0]       pick_idx_s;
    logic [PTR_W:0]         cand_s;

`ifdef ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             arb_error_q, arb_error_d;
`endif

    // Round-robin search: first requesting core at or above rr_ptr, wrapping to 0.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            cand_s = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            cand_s = (cand_s >= (PTR_W+1)'(CORE_COUNT)) ? cand_s - (PTR_W+1)'(CORE_COUNT) : cand_s;
            if (!pick_found_s && (en_s[cand_s[PTR_W-1:0]] != '0)) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s[PTR_W-1:0];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Next-state and registered-output computation for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        req_en_d     = req_en_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        rd_data_d    = rd_data_q;
        core_ready_d = '0;
        mem_enable_d = mem_enable_q;
`ifdef ARB_TIMEOUT_EN
        timer_d      = timer_q;
        arb_error_d  = arb_error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                mem_enable_d = '0;
                if (pick_found_s) begin
                    state_d      = ST_BUSY;
                    grant_d      = pick_idx_s;
                    req_en_d     = en_s[pick_idx_s];
                    req_addr_d   = addr_s[pick_idx_s];
                    req_wdata_d  = wdata_s[pick_idx_s];
                    mem_enable_d = en_s[pick_idx_s];
`ifdef ARB_TIMEOUT_EN
                    timer_d      = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    state_d      = ST_DONE;
                    mem_enable_d = '0;
                    rd_data_d    = (req_en_q == ENABLE_WRITE) ? '0 : mem_rd_data;
                    core_ready_d = {{(CORE_COUNT-1){1'b0}}, 1'b1} << grant_q;
`ifdef ARB_TIMEOUT_EN
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = ST_DONE;
                    mem_enable_d = '0;
                    rd_data_d    = '0;
                    arb_error_d  = 1'b1;
                    core_ready_d = {{(CORE_COUNT-1){1'b0}}, 1'b1} << grant_q;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
`else
                end else begin
                    state_d = ST_BUSY;
                end
`endif
            end
            ST_DONE: begin
                // No grant here: a request still held goes through IDLE again first.
                state_d      = ST_IDLE;
                mem_enable_d = '0;
                rr_ptr_d     = (grant_q == PTR_W'(CORE_COUNT - 1)) ? '0 : grant_q + PTR_W'(1);
            end
            default: begin
                state_d      = ST_IDLE;
                mem_enable_d = '0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously so an aborted transaction leaves no trace.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            req_en_q     <= '0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            rd_data_q    <= '0;
            core_ready_q <= '0;
            mem_enable_q <= '0;
`ifdef ARB_TIMEOUT_EN
            timer_q      <= '0;
            arb_error_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            req_en_q     <= req_en_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            rd_data_q    <= rd_data_d;
            core_ready_q <= core_ready_d;
            mem_enable_q <= mem_enable_d;
`ifdef ARB_TIMEOUT_EN
            timer_q      <= timer_d;
            arb_error_q  <= arb_error_d;
`endif
        end
    end

    assign core_ready   = core_ready_q;
    assign core_rd_data = rd_data_q;
    assign mem_enable   = mem_enable_q;
    assign mem_addr     = req_addr_q;
    assign mem_wr_data  = req_wdata_q;
`ifdef ARB_TIMEOUT_EN
    assign arb_error    = arb_error_q;
`else
    assign arb_error    = 1'b0;
`endif

endmodule
